vpu_sparse_feeder: RTL
======================

# vpu_sparse_feeder

Job-level initiator for the vector processing unit (VPU). Accepts one dense job (NUM_DGS activation lanes plus NUM_DGS weight lanes) over a valid/ready handshake and builds the per-DSP-group sparsity mask from zero weights. It streams the non-zero lanes into the VPU with a start pulse, waits for the VPU done flag, and returns the accumulated result over a second valid/ready handshake. It sits between the operand buffer and the VPU and owns all VPU control sequencing.

## Interface
- NUM_DGS, 4, DSP groups in the VPU; also the lane count per job
- DATA_WIDTH, 8, activation/weight lane width
- ACCUM_WIDTH, 48, VPU result width
- SPARSE_INDEX_WIDTH, 4, mask width; must equal NUM_DGS
- TIMEOUT_CYCLES, 1024, maximum WAIT_DONE dwell before the job is aborted
- clk  in  1  single clock, all logic rising-edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  job offered
- in_ready  out  1  job accepted when in_valid & in_ready
- in_act  in  NUM_DGS*DATA_WIDTH  activation lanes; lane i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- in_wgt  in  NUM_DGS*DATA_WIDTH  weight lanes, same packing
- vpu_start  out  1  one-cycle pulse on the first beat of a job
- vpu_beat  out  1  activation/weight beat valid this cycle
- vpu_activation  out  DATA_WIDTH  streamed activation
- vpu_weight  out  DATA_WIDTH  streamed weight
- vpu_sparse_index  out  SPARSE_INDEX_WIDTH  bit i = 1 when weight lane i is zero; held stable for the whole job
- vpu_done  in  1  VPU completion, sampled only in WAIT_DONE
- vpu_result  in  ACCUM_WIDTH  VPU output, captured on vpu_done
- out_valid  out  1  result available
- out_ready  in  1  result consumed when out_valid & out_ready
- out_data  out  ACCUM_WIDTH  registered result
- out_err  out  1  qualifies out_data; 1 = timeout abort
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, STREAM, WAIT_DONE, RESULT.
- IDLE: in_ready=1. On accept, register in_act, in_wgt and mask[i] = (wgt lane i == 0).
  - If the mask is all ones, go to RESULT with out_data=0, out_err=0, and issue no VPU traffic.
  - Otherwise go to STREAM.
- STREAM: each cycle emit one non-zero lane, in ascending lane index, with vpu_beat=1. vpu_start=1 on the first beat only. After the last non-zero lane, go to WAIT_DONE. Beat count = NUM_DGS − popcount(mask).
- WAIT_DONE:
  - vpu_beat=0.
  - On vpu_done=1: capture vpu_result into out_data, set out_err=0, go to RESULT.
  - A timeout counter is cleared on entry and increments each cycle. When it reaches TIMEOUT_CYCLES−1 without done, go to RESULT with out_data=0, out_err=1.
  - If done and the timeout occur in the same cycle, done wins.
- RESULT: out_valid=1; out_data and out_err are held stable. On out_ready go to IDLE. No new job is accepted in the same cycle.
- vpu_done asserted outside WAIT_DONE is ignored.
- vpu_sparse_index shows the registered mask from the STREAM entry through the WAIT_DONE exit, and 0 otherwise.
- vpu_activation/vpu_weight are 0 when vpu_beat=0.

## Timing
- Reset (async assert, sync release):
  - state=IDLE; mask, out_data, counter = 0.
  - Outputs: in_ready=1 once rst_n is high; vpu_start, vpu_beat, out_valid, out_err, busy = 0; vpu_activation, vpu_weight, vpu_sparse_index, out_data = 0.
- Reset mid-job aborts immediately. No result is produced and no done is awaited after release.
- Accept at cycle T:
  - Beats occur at T+1 .. T+N (N non-zero lanes).
  - WAIT_DONE is entered at T+N+1.
  - vpu_done sampled high at cycle D gives out_valid=1 at D+1.
- All-zero job: out_valid=1 at T+1.
- Timeout: out_valid=1 exactly TIMEOUT_CYCLES cycles after WAIT_DONE entry.
- Throughput: at most one job in flight. After out_ready at cycle R, in_ready=1 at R+1.
- All outputs are registered or decoded from registered state only. No combinational path from any input to any output.

## Test plan
- Dense job, act={1,2,3,4}, wgt={5,6,7,8}: 4 beats with lanes 0..3 in order, start only on beat 1, sparse_index=0000. Drive done 3 cycles after the last beat with result 70 -> out_data=70, out_err=0, out_valid one cycle after done.
- Sparse job, wgt={0,6,0,8}: sparse_index=0101 held through WAIT_DONE, exactly 2 beats (lane 1, then lane 3), start on the lane-1 beat.
- All-zero weights: no vpu_start and no beats; out_valid at T+1 with out_data=0, out_err=0.
- TIMEOUT_CYCLES=16, no done: out_valid 16 cycles after WAIT_DONE entry with out_err=1, out_data=0. A subsequent job completes normally.
- Backpressure and stray done: hold out_ready=0 for 10 cycles and pulse vpu_done during RESULT and during STREAM -> out_data unchanged, in_ready stays 0 until out_ready, and the stray done is ignored.
- Reset asserted in the middle of STREAM: all outputs return to their reset values asynchronously, in_ready=1 after release, and the next job runs cleanly.

Source files
------------

// File: rtl/vpu_sparse_feeder.sv
// vpu_sparse_feeder: accepts a dense job, streams its non-zero-weight lanes into the VPU and returns the result
module vpu_sparse_feeder #(
  parameter int NUM_DGS = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ACCUM_WIDTH = 48,
  parameter int SPARSE_INDEX_WIDTH = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_DGS*DATA_WIDTH-1:0] in_act,
  input  logic [NUM_DGS*DATA_WIDTH-1:0] in_wgt,
  output logic                          vpu_start,
  output logic                          vpu_beat,
  output logic [DATA_WIDTH-1:0]         vpu_activation,
  output logic [DATA_WIDTH-1:0]         vpu_weight,
  output logic [SPARSE_INDEX_WIDTH-1:0] vpu_sparse_index,
  input  logic                          vpu_done,
  input  logic [ACCUM_WIDTH-1:0]        vpu_result,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ACCUM_WIDTH-1:0]        out_data,
  output logic                          out_err,
  output logic                          busy
);
  localparam int IW = NUM_DGS > 1 ? $clog2(NUM_DGS) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  typedef enum logic [1:0] {IDLE, STREAM, WAIT_DONE, RESULT} state_t;
  state_t state, state_nxt;
  logic [NUM_DGS*DATA_WIDTH-1:0] act, wgt;
  logic [NUM_DGS-1:0] mask, in_mask;
  logic [IW-1:0] idx, nxt_idx, in_idx;
  logic nxt_found, first, timeout, accept;
  logic [CW-1:0] cnt;
  assign accept = state == IDLE && in_valid;
  assign timeout = cnt == CW'(TIMEOUT_CYCLES - 1);
  // zero-weight mask of the offered job and the lane searches (lowest candidate wins)
  always_comb begin
    in_mask = '0;
    in_idx = '0;
    nxt_idx = '0;
    nxt_found = 1'b0;
    for (int i = 0; i < NUM_DGS; i++) in_mask[i] = in_wgt[i*DATA_WIDTH +: DATA_WIDTH] == '0;
    for (int i = NUM_DGS - 1; i >= 0; i--) begin
      if (!in_mask[i]) in_idx = IW'(i);
      if (i > int'(idx) && !mask[i]) begin
        nxt_idx = IW'(i);
        nxt_found = 1'b1;
      end
    end
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  // next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (in_valid) state_nxt = &in_mask ? RESULT : STREAM;
      STREAM:    if (!nxt_found) state_nxt = WAIT_DONE;
      WAIT_DONE: if (vpu_done || timeout) state_nxt = RESULT;
      RESULT:    if (out_ready) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end
  // job operands, lane pointer, timeout counter and result capture
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      act <= '0;
      wgt <= '0;
      mask <= '0;
      idx <= '0;
      first <= 1'b0;
      cnt <= '0;
      out_data <= '0;
      out_err <= 1'b0;
    end else begin
      if (accept) begin
        act <= in_act;
        wgt <= in_wgt;
        mask <= in_mask;
        idx <= in_idx;
        first <= 1'b1;
        out_data <= '0;
        out_err <= 1'b0;
      end
      if (state == STREAM) begin
        idx <= nxt_idx;
        first <= 1'b0;
      end
      cnt <= state == WAIT_DONE ? cnt + 1'b1 : '0;
      if (state == WAIT_DONE && vpu_done) begin
        out_data <= vpu_result;
        out_err <= 1'b0;
      end else if (state == WAIT_DONE && timeout) begin
        out_data <= '0;
        out_err <= 1'b1;
      end
    end
  assign in_ready = state == IDLE;
  assign busy = state != IDLE;
  assign out_valid = state == RESULT;
  assign vpu_beat = state == STREAM;
  assign vpu_start = vpu_beat && first;
  assign vpu_activation = vpu_beat ? act[idx*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign vpu_weight = vpu_beat ? wgt[idx*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign vpu_sparse_index = (state == STREAM || state == WAIT_DONE) ? mask : '0;
endmodule
